issue_stage: RTL and testbench

Issue/operand-fetch stage of the 16-bit CPU, directly upstream of the add/sub/mul/div execute units. Accepts one 16-bit instruction per cycle, reads two 16-bit source operands from an 8-entry register file, and blocks on register hazards with a pending-write scoreboard. Presents opcode, destination, rs1 and rs2 values to execute over a valid/ready handshake, and takes results back through a writeback port.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/issue_stage_if.sv | 30 +++
 rtl/cpu_regfile.sv | 32 +++
 rtl/issue_stage.sv | 120 ++++++++++++
 tb/tb_issue_stage.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared constants, opcode enum and instruction field positions for the 16-bit CPU.
package cpu_pkg;

    localparam int NREGS = 8;
    localparam int DW    = 16;
    localparam int RW    = $clog2(NREGS);

    localparam int OPC_LSB = 12;
    localparam int OPC_W   = 4;
    localparam int RD_LSB  = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 3;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_e;

    typedef logic [RW-1:0] ridx_t;

    // Only opcodes 0..3 map onto an execute unit.
    function automatic logic op_legal(input logic [OPC_W-1:0] opc);
        return opc[OPC_W-1:2] == 2'b00;
    endfunction

endpackage

// File: rtl/issue_stage_if.sv
// Issue stage bus: instruction input, execute handshake, writeback port and scoreboard view.
interface issue_stage_if;
    import cpu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_instr;
    logic             ex_valid;
    logic             ex_ready;
    op_e              ex_op;
    ridx_t            ex_rd;
    logic [DW-1:0]    ex_rs1;
    logic [DW-1:0]    ex_rs2;
    logic             wb_valid;
    ridx_t            wb_rd;
    logic [DW-1:0]    wb_data;
    logic             illegal;
    logic [NREGS-1:0] pending;

    modport master (
        output in_valid, in_instr, ex_ready, wb_valid, wb_rd, wb_data,
        input  in_ready, ex_valid, ex_op, ex_rd, ex_rs1, ex_rs2, illegal, pending
    );

    modport slave (
        input  in_valid, in_instr, ex_ready, wb_valid, wb_rd, wb_data,
        output in_ready, ex_valid, ex_op, ex_rd, ex_rs1, ex_rs2, illegal, pending
    );

endinterface

// File: rtl/cpu_regfile.sv
// 8x16 register file: two asynchronous read ports, one synchronous write port, r0 hardwired to 0.
module cpu_regfile
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  ridx_t         i_ra,
    input  ridx_t         i_rb,
    output logic [DW-1:0] o_da,
    output logic [DW-1:0] o_db,
    input  logic          i_we,
    input  ridx_t         i_wa,
    input  logic [DW-1:0] i_wd
);

    logic [DW-1:0] r_mem [NREGS];

    // r0 is never written, so it keeps its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && i_wa != '0) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    assign o_da = r_mem[i_ra];
    assign o_db = r_mem[i_rb];

endmodule

// File: rtl/issue_stage.sv
// Issue/operand-fetch stage with pending-write scoreboard and registered execute output.
// Optional writeback-to-operand forwarding is enabled by defining ISSUE_BYPASS_EN.
module issue_stage
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    issue_stage_if.slave bus
);

    logic [OPC_W-1:0] w_opc;
    ridx_t            w_rd, w_rs1, w_rs2;
    logic [2:0]       w_unused_bits;
    logic             w_legal;
    logic [DW-1:0]    w_rf1, w_rf2, w_src1, w_src2;
    logic             w_byp1, w_byp2, w_byp_rd;
    logic             w_haz, w_slot_free, w_in_ready, w_accept, w_issue;
    logic [NREGS-1:0] w_set, w_clr;

    logic [NREGS-1:0] r_pending;
    logic             r_ex_valid;
    op_e              r_ex_op;
    ridx_t            r_ex_rd;
    logic [DW-1:0]    r_ex_rs1, r_ex_rs2;
    logic             r_illegal;

    assign w_opc         = bus.in_instr[OPC_LSB +: OPC_W];
    assign w_rd          = bus.in_instr[RD_LSB  +: RW];
    assign w_rs1         = bus.in_instr[RS1_LSB +: RW];
    assign w_rs2         = bus.in_instr[RS2_LSB +: RW];
    assign w_unused_bits = bus.in_instr[2:0];
    assign w_legal       = op_legal(w_opc);

    cpu_regfile u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .i_ra  (w_rs1),
        .i_rb  (w_rs2),
        .o_da  (w_rf1),
        .o_db  (w_rf2),
        .i_we  (bus.wb_valid),
        .i_wa  (bus.wb_rd),
        .i_wd  (bus.wb_data)
    );

`ifdef ISSUE_BYPASS_EN
    assign w_byp1   = bus.wb_valid && bus.wb_rd == w_rs1 && w_rs1 != '0;
    assign w_byp2   = bus.wb_valid && bus.wb_rd == w_rs2 && w_rs2 != '0;
    assign w_byp_rd = bus.wb_valid && bus.wb_rd == w_rd;
`else
    assign w_byp1   = 1'b0;
    assign w_byp2   = 1'b0;
    assign w_byp_rd = 1'b0;
`endif

    assign w_src1 = w_byp1 ? bus.wb_data : w_rf1;
    assign w_src2 = w_byp2 ? bus.wb_data : w_rf2;

    // RAW on either source plus WAW on rd; a register being forwarded this cycle is safe.
    assign w_haz       = (r_pending[w_rs1] & ~w_byp1)
                       | (r_pending[w_rs2] & ~w_byp2)
                       | (r_pending[w_rd]  & ~w_byp_rd);
    assign w_slot_free = ~r_ex_valid | bus.ex_ready;
    assign w_in_ready  = w_slot_free & (~w_legal | ~w_haz);
    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_issue     = w_accept & w_legal;

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_sb
            localparam ridx_t IDX = ridx_t'(gi);
            assign w_set[gi] = w_issue && w_rd == IDX && IDX != '0;
            assign w_clr[gi] = bus.wb_valid && bus.wb_rd == IDX;
        end
    endgenerate

    // Set is applied after clear so a same-cycle issue/writeback to one register stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid <= 1'b0;
            r_ex_op    <= OP_ADD;
            r_ex_rd    <= '0;
            r_ex_rs1   <= '0;
            r_ex_rs2   <= '0;
            r_illegal  <= 1'b0;
        end else begin
            r_illegal <= w_accept & ~w_legal;
            if (w_issue) begin
                r_ex_valid <= 1'b1;
                r_ex_op    <= op_e'(w_opc[1:0]);
                r_ex_rd    <= w_rd;
                r_ex_rs1   <= w_src1;
                r_ex_rs2   <= w_src2;
            end else if (bus.ex_ready) begin
                r_ex_valid <= 1'b0;
                r_ex_op    <= OP_ADD;
                r_ex_rd    <= '0;
                r_ex_rs1   <= '0;
                r_ex_rs2   <= '0;
            end
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.ex_valid = r_ex_valid;
    assign bus.ex_op    = r_ex_op;
    assign bus.ex_rd    = r_ex_rd;
    assign bus.ex_rs1   = r_ex_rs1;
    assign bus.ex_rs2   = r_ex_rs2;
    assign bus.illegal  = r_illegal;
    assign bus.pending  = r_pending;

endmodule

// File: tb/tb_issue_stage.sv
// Self-checking bench for issue_stage: vector table plus hand-written stall, hazard and reset sequences.
module tb_issue_stage;
    import cpu_pkg::*;

    typedef struct packed {
        logic [1:0]  op;
        logic [2:0]  rd;
        logic [15:0] a;
        logic [15:0] b;
    } ex_t;

    typedef struct {
        logic [15:0] instr;
        logic        ill;
        ex_t         ex;
        logic [15:0] wbval;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    issue_stage_if bus();

    issue_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    ex_t  sb_q[$];
    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic ex_t mkex(input logic [1:0] op, input logic [2:0] rd,
                                 input logic [15:0] a, input logic [15:0] b);
        return {op, rd, a, b};
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        chk({tag, "_ex_valid"}, 64'(bus.ex_valid), 64'd0);
        chk({tag, "_ex_fields"}, 64'({bus.ex_op, bus.ex_rd, bus.ex_rs1, bus.ex_rs2}), 64'd0);
        chk({tag, "_illegal"}, 64'(bus.illegal), 64'd0);
        chk({tag, "_pending"}, 64'(bus.pending), 64'd0);
    endtask

    task automatic wb_write(input logic [2:0] rd, input logic [15:0] d);
        @(negedge clk);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = rd;
        bus.wb_data  = d;
        @(negedge clk);
        bus.wb_valid = 1'b0;
    endtask

    // Presents an instruction until accepted; returns on the negedge after the accepting edge.
    task automatic issue(input logic [15:0] instr, input ex_t e, input logic push);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        #1;
        for (int k = 0; k < 20 && bus.in_ready !== 1'b1; k++) begin
            @(negedge clk);
            #1;
        end
        chk("issue_accept", 64'(bus.in_ready), 64'd1);
        if (push) sb_q.push_back(e);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_instr = 16'h0000;
    endtask

    // Scoreboard consumer: each op handed to execute is checked against the oldest expectation.
    always begin : monitor
        ex_t got;
        ex_t exp_e;
        @(negedge clk);
        #2;
        if (rst_n === 1'b1 && bus.ex_valid === 1'b1 && bus.ex_ready === 1'b1) begin
            got = {bus.ex_op, bus.ex_rd, bus.ex_rs1, bus.ex_rs2};
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL ex_unexpected: got op=%0d rd=%0d rs1=%h rs2=%h, required no operation",
                         got.op, got.rd, got.a, got.b);
            end else begin
                exp_e = sb_q.pop_front();
                $display("ex op=%0d rd=%0d rs1=%h rs2=%h", got.op, got.rd, got.a, got.b);
                chk("ex_issue", 64'(got), 64'(exp_e));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_p;

        vecs[0] = '{16'h3650, 1'b0, mkex(2'd3, 3'd3, 16'd12,    16'd12),    16'd1};
        vecs[1] = '{16'h0858, 1'b0, mkex(2'd0, 3'd4, 16'd12,    16'd1),     16'd13};
        vecs[2] = '{16'h1B10, 1'b0, mkex(2'd1, 3'd5, 16'd13,    16'd12),    16'd1};
        vecs[3] = '{16'h0000, 1'b0, mkex(2'd0, 3'd0, 16'd0,     16'd0),     16'h1234};
        vecs[4] = '{16'h2D40, 1'b0, mkex(2'd2, 3'd6, 16'd1,     16'd0),     16'h00AA};
        vecs[5] = '{16'hF000, 1'b1, mkex(2'd0, 3'd0, 16'd0,     16'd0),     16'd0};
        vecs[6] = '{16'h8E00, 1'b1, mkex(2'd0, 3'd0, 16'd0,     16'd0),     16'd0};
        vecs[7] = '{16'h0FB0, 1'b0, mkex(2'd0, 3'd7, 16'h00AA,  16'h00AA),  16'hFFFF};
        vecs[8] = '{16'h13E8, 1'b0, mkex(2'd1, 3'd1, 16'hFFFF,  16'd1),     16'h5555};
        vecs[9] = '{16'h0000, 1'b0, mkex(2'd0, 3'd0, 16'd0,     16'd0),     16'd0};

        bus.in_valid = 1'b0;
        bus.in_instr = 16'h0000;
        bus.ex_ready = 1'b0;
        bus.wb_valid = 1'b0;
        bus.wb_rd    = 3'd0;
        bus.wb_data  = 16'h0000;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_reset("reset");
        rst_n = 1'b1;

        // Basic issue: div r3,r1,r2
        bus.ex_ready = 1'b1;
        wb_write(3'd1, 16'd12);
        wb_write(3'd2, 16'd12);
        issue(16'h3650, mkex(2'd3, 3'd3, 16'd12, 16'd12), 1'b1);
        #1;
        chk("t1_ex_valid", 64'(bus.ex_valid), 64'd1);
        chk("t1_pending", 64'(bus.pending), 64'h08);

        // RAW hazard on r3, released by writeback r3=1
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_instr = 16'h0858;
        for (int k = 0; k < 3; k++) begin
            #1 chk("t2_stall_ready", 64'(bus.in_ready), 64'd0);
            @(negedge clk);
        end
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 3'd3;
        bus.wb_data  = 16'd1;
        #1;
`ifdef ISSUE_BYPASS_EN
        chk("t2_bypass_ready", 64'(bus.in_ready), 64'd1);
        sb_q.push_back(mkex(2'd0, 3'd4, 16'd12, 16'd1));
        @(negedge clk);
        bus.wb_valid = 1'b0;
        bus.in_valid = 1'b0;
`else
        chk("t2_wb_cycle_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        bus.wb_valid = 1'b0;
        #1 chk("t2_after_wb_ready", 64'(bus.in_ready), 64'd1);
        sb_q.push_back(mkex(2'd0, 3'd4, 16'd12, 16'd1));
        @(negedge clk);
        bus.in_valid = 1'b0;
`endif
        #1 chk("t2_pending", 64'(bus.pending), 64'h10);
        wb_write(3'd4, 16'd13);

        // Back-pressure: held output must stay stable, queued instruction waits
        bus.ex_ready = 1'b0;
        issue(16'h1A50, mkex(2'd1, 3'd5, 16'd12, 16'd12), 1'b1);
        bus.in_valid = 1'b1;
        bus.in_instr = 16'h0C48;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_hold_ready", 64'(bus.in_ready), 64'd0);
            chk("t3_hold_valid", 64'(bus.ex_valid), 64'd1);
            chk("t3_hold_fields", 64'({bus.ex_op, bus.ex_rd, bus.ex_rs1, bus.ex_rs2}),
                64'(mkex(2'd1, 3'd5, 16'd12, 16'd12)));
            @(negedge clk);
        end
        bus.ex_ready = 1'b1;
        #1 chk("t3_release_ready", 64'(bus.in_ready), 64'd1);
        sb_q.push_back(mkex(2'd0, 3'd6, 16'd12, 16'd12));
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1 chk("t3_pending", 64'(bus.pending), 64'h60);
        wb_write(3'd5, 16'd0);
        wb_write(3'd6, 16'd0);

        // Vector table: each legal op is retired by a writeback of its rd
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].instr, vecs[i].ex, !vecs[i].ill);
            #1;
            exp_p = (!vecs[i].ill && vecs[i].ex.rd != 3'd0) ? (8'h01 << vecs[i].ex.rd) : 8'h00;
            chk("vec_illegal", 64'(bus.illegal), 64'(vecs[i].ill));
            chk("vec_ex_valid", 64'(bus.ex_valid), 64'(!vecs[i].ill));
            chk("vec_pending", 64'(bus.pending), 64'(exp_p));
            if (vecs[i].ill) begin
                @(negedge clk);
                #1 chk("vec_illegal_pulse_end", 64'(bus.illegal), 64'd0);
            end else begin
                wb_write(vecs[i].ex.rd, vecs[i].wbval);
            end
        end
        @(negedge clk);
        #3 chk("sb_empty", 64'(sb_q.size()), 64'd0);

        // Reset while stalled with r3 pending and an op held
        bus.ex_ready = 1'b0;
        issue(16'h3650, mkex(2'd3, 3'd3, 16'h5555, 16'd12), 1'b1);
        bus.in_valid = 1'b1;
        bus.in_instr = 16'h0858;
        #1;
        chk("t6_pre_ready", 64'(bus.in_ready), 64'd0);
        chk("t6_pre_pending", 64'(bus.pending), 64'h08);
        chk("t6_pre_rs1", 64'(bus.ex_rs1), 64'h5555);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_reset("t6_reset");
        sb_q.delete();
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.ex_ready = 1'b1;
        issue(16'h0850, mkex(2'd0, 3'd4, 16'd0, 16'd0), 1'b1);
        @(negedge clk);
        #3 chk("t6_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
